// File: rtl/alu_pkg.sv
// Shared constants and types for the two-pass 32-bit add/sub sequencer.
package alu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Upper operand halves kept for the second pass; b_hi is already inverted for sub.
  typedef struct packed {
    logic [HALF_W-1:0] a_hi;
    logic [HALF_W-1:0] b_hi;
  } hi_op_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_rr_arb.sv
// Request arbiter: round robin starting at ptr, or fixed lowest-index priority
// when ADDSUB_SEQ_PRIO_EN is defined (the ptr port is then absent).
module addsub_rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [NREQ-1:0] req,
`ifndef ADDSUB_SEQ_PRIO_EN
  input  logic [ID_W-1:0] ptr,
`endif
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
`ifndef ADDSUB_SEQ_PRIO_EN
    // First pass covers indices at or above the pointer; the wrap pass below finishes the ring.
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        id       = ID_W'(i);
      end
    end
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        id       = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/addsub32_seq_arbiter.sv
// Shares one external 16-bit adder among NREQ requesters, running each 32-bit
// add/sub as a low pass then a carry-chained high pass. ADDSUB_SEQ_PRIO_EN selects fixed priority.
module addsub32_seq_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_sub,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  output logic [HALF_W-1:0]      add_a,
  output logic [HALF_W-1:0]      add_b,
  output logic                   add_cin,
  input  logic [HALF_W-1:0]      add_s,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WORD_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf
);

  state_t              state;
  hi_op_t              op;
  logic [ID_W-1:0]     op_id;
  logic [HALF_W-1:0]   sum_lo;

  logic [NREQ-1:0]     arb_req;
  logic [NREQ-1:0]     gnt;
  logic [ID_W-1:0]     gid;
  logic                any;

  logic [WORD_W-1:0]   sel_a;
  logic [WORD_W-1:0]   sel_b;
  logic                sel_sub;

  // Grants only happen in IDLE, and never while reset is asserted.
  assign arb_req   = ((state == ST_IDLE) && reset_n) ? req_valid : '0;
  assign req_ready = gnt;

`ifndef ADDSUB_SEQ_PRIO_EN
  logic [ID_W-1:0] ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (32'(gid) == NREQ - 1) ? '0 : gid + ID_W'(1);
    end
  end
`endif

  addsub_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req   (arb_req),
`ifndef ADDSUB_SEQ_PRIO_EN
    .ptr   (ptr),
`endif
    .grant (gnt),
    .id    (gid),
    .any   (any)
  );

  // One-hot operand select for the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[i*WORD_W +: WORD_W];
        sel_b   = req_b[i*WORD_W +: WORD_W] ^ {WORD_W{req_sub[i]}};
        sel_sub = req_sub[i];
      end
    end
  end

  // Sequencer: adder inputs are registered one pass ahead so they are valid for the whole LO/HI cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op        <= '0;
      op_id     <= '0;
      sum_lo    <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            op.a_hi <= sel_a[WORD_W-1:HALF_W];
            op.b_hi <= sel_b[WORD_W-1:HALF_W];
            op_id   <= gid;
            add_a   <= sel_a[HALF_W-1:0];
            add_b   <= sel_b[HALF_W-1:0];
            add_cin <= sel_sub;
            state   <= ST_LO;
          end
        end
        ST_LO: begin
          // add_cin doubles as the carry register between passes.
          sum_lo  <= add_s;
          add_a   <= op.a_hi;
          add_b   <= op.b_hi;
          add_cin <= add_cout;
          state   <= ST_HI;
        end
        ST_HI: begin
          rsp_sum   <= {add_s, sum_lo};
          rsp_cout  <= add_cout;
          rsp_ovf   <= signed_ovf(op.a_hi[HALF_W-1], op.b_hi[HALF_W-1], add_s[HALF_W-1]);
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          add_a     <= '0;
          add_b     <= '0;
          add_cin   <= 1'b0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub32_seq_arbiter.sv
// Directed and randomized bench for addsub32_seq_arbiter with a behavioural
// 16-bit adder and an arithmetic reference model.
module tb_addsub32_seq_arbiter;

  localparam int unsigned NREQ = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NREQ-1:0]  req_valid, req_ready, req_sub;
  logic [63:0]      req_a, req_b;
  logic [15:0]      add_a, add_b, add_s;
  logic             add_cin, add_cout;
  logic             rsp_valid, rsp_ready;
  logic [0:0]       rsp_id;
  logic [31:0]      rsp_sum;
  logic             rsp_cout, rsp_ovf;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  int fair_seq [4];

  logic [31:0] obs_sum;
  logic        obs_cout, obs_ovf;
  int          obs_id;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  addsub32_seq_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [1:0] v);
`ifdef ADDSUB_SEQ_PRIO_EN
    return v[0] ? 0 : 1;
`else
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (ptr_m + k) % 2;
      if (v[idx[0]]) return idx;
    end
    return 0;
`endif
  endfunction

  task automatic set_op(input bit i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (i) begin
      req_a[63:32] = a; req_b[63:32] = b; req_sub[1] = sub;
    end else begin
      req_a[31:0] = a; req_b[31:0] = b; req_sub[0] = sub;
    end
  endtask

  // Called at a falling edge with the DUT idle and requests already driven.
  task automatic transact(input bit drop, input int hold);
    int          g;
    logic [31:0] a, b, bx, s_e;
    logic        sub, c16_e, cout_e, ovf_e;
    longint      ru, rs;
    #1;
    g   = model_grant(req_valid);
    a   = g[0] ? req_a[63:32] : req_a[31:0];
    b   = g[0] ? req_b[63:32] : req_b[31:0];
    sub = g[0] ? req_sub[1] : req_sub[0];
    bx  = sub ? ~b : b;
    if (sub) begin
      ru     = longint'(a) - longint'(b);
      rs     = longint'($signed(a)) - longint'($signed(b));
      cout_e = (a >= b);
      c16_e  = (a[15:0] >= b[15:0]);
    end else begin
      ru     = longint'(a) + longint'(b);
      rs     = longint'($signed(a)) + longint'($signed(b));
      cout_e = (ru > 64'sd4294967295);
      c16_e  = ((32'(a[15:0]) + 32'(b[15:0])) > 32'hFFFF);
    end
    s_e   = ru[31:0];
    ovf_e = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);

    chk("grant", 64'(req_ready), 64'(1) << g);
    ptr_m = (g + 1) % 2;

    @(posedge clk); #1;
    if (drop) req_valid[g[0]] = 1'b0;
    set_op(g[0], $urandom, $urandom, sub);

    @(negedge clk);
    chk("lo_add_a", 64'(add_a), 64'(a[15:0]));
    chk("lo_add_b", 64'(add_b), 64'(bx[15:0]));
    chk("lo_cin", 64'(add_cin), 64'(sub));
    chk("lo_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("lo_ready", 64'(req_ready), 64'(0));

    @(negedge clk);
    chk("hi_add_a", 64'(add_a), 64'(a[31:16]));
    chk("hi_add_b", 64'(add_b), 64'(bx[31:16]));
    chk("hi_cin", 64'(add_cin), 64'(c16_e));
    chk("hi_rsp_valid", 64'(rsp_valid), 64'(0));

    @(negedge clk);
    chk("resp_valid", 64'(rsp_valid), 64'(1));
    chk("resp_id", 64'(rsp_id), 64'(g));
    chk("resp_sum", 64'(rsp_sum), 64'(s_e));
    chk("resp_cout", 64'(rsp_cout), 64'(cout_e));
    chk("resp_ovf", 64'(rsp_ovf), 64'(ovf_e));
    chk("resp_add_a", 64'(add_a), 64'(0));
    chk("resp_ready", 64'(req_ready), 64'(0));
    obs_sum  = rsp_sum;
    obs_cout = rsp_cout;
    obs_ovf  = rsp_ovf;
    obs_id   = int'(rsp_id);

    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", 64'(rsp_valid), 64'(1));
        chk("hold_sum", 64'(rsp_sum), 64'(s_e));
        chk("hold_id", 64'(rsp_id), 64'(g));
        chk("hold_ready", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
    end

    @(negedge clk);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("idle_add_a", 64'(add_a), 64'(0));
  endtask

  initial begin
`ifdef ADDSUB_SEQ_PRIO_EN
    fair_seq = '{0, 0, 0, 0};
`else
    fair_seq = '{0, 1, 0, 1};
`endif
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Reset state, including a pending request that must not be granted.
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_add_a", 64'(add_a), 64'(0));
    chk("rst_add_b", 64'(add_b), 64'(0));
    chk("rst_cin", 64'(add_cin), 64'(0));
    chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", 64'(req_ready), 64'(0));

    req_valid = 2'b01; set_op(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0);
    transact(1'b1, 0);
    chk("t1_sum", 64'(obs_sum), 64'h00010000);
    chk("t1_cout", 64'(obs_cout), 64'(0));
    chk("t1_ovf", 64'(obs_ovf), 64'(0));
    chk("t1_id", 64'(obs_id), 64'(0));

    req_valid = 2'b10; set_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    transact(1'b1, 0);
    chk("ovf_sum", 64'(obs_sum), 64'h80000000);
    chk("ovf_ovf", 64'(obs_ovf), 64'(1));
    chk("ovf_cout", 64'(obs_cout), 64'(0));

    req_valid = 2'b01; set_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    transact(1'b1, 0);
    chk("wrap_sum", 64'(obs_sum), 64'(0));
    chk("wrap_cout", 64'(obs_cout), 64'(1));
    chk("wrap_ovf", 64'(obs_ovf), 64'(0));

    req_valid = 2'b10; set_op(1'b1, 32'd5, 32'd7, 1'b1);
    transact(1'b1, 0);
    chk("sub_sum", 64'(obs_sum), 64'hFFFFFFFE);
    chk("sub_cout", 64'(obs_cout), 64'(0));
    chk("sub_ovf", 64'(obs_ovf), 64'(0));
    chk("sub_id", 64'(obs_id), 64'(1));

    // Both requesters held high throughout.
    req_valid = 2'b11;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_sub = 2'($urandom);
    for (int n = 0; n < 4; n++) begin
      transact(1'b0, 0);
      chk("fair_id", 64'(obs_id), 64'(fair_seq[n]));
    end

    // Response back-pressure with another request waiting.
    req_valid = 2'b11;
    transact(1'b1, 5);

    for (int n = 0; n < 20; n++) begin
      req_valid = 2'($urandom_range(1, 3));
      req_sub   = 2'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = (n % 5 == 0) ? req_a : {$urandom, $urandom};
      transact(1'b1, $urandom_range(0, 2));
    end

    // Reset asserted while the high pass is in flight.
    req_valid = 2'b01; set_op(1'b0, $urandom, $urandom, 1'b0);
    #1;
    chk("mid_grant", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    ptr_m   = 0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_add_a", 64'(add_a), 64'(0));
    chk("mid_rst_add_b", 64'(add_b), 64'(0));
    chk("mid_rst_cin", 64'(add_cin), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_rsp_sum", 64'(rsp_sum), 64'(0));
    chk("mid_rst_rsp_misc", 64'({rsp_id, rsp_cout, rsp_ovf}), 64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_hold_valid", 64'(rsp_valid), 64'(0));
    end
    reset_n = 1'b1;
    transact(1'b1, 0);
    chk("mid_rst_first_id", 64'(obs_id), 64'(0));
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(rsp_valid), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
